// File: rtl/v_meminit.sv
// Memory initialiser: sweeps addresses 0..N-1 across a set of banks with a
// selectable data pattern, automatically after reset or on request.
module v_meminit #(
  parameter int N             = 256,
  parameter int W             = 32,
  parameter int BANKS         = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [1:0]                    i_mode,
  input  logic [W-1:0]                  i_fill,
  input  logic [BANKS-1:0]              i_bank_mask,
  input  logic                          i_stall,
  output logic [BANKS-1:0]              o_wen_r,
  output logic [((N > 2) ? $clog2(N) : 1)-1:0] o_waddr_r,
  output logic [W-1:0]                  o_wdata_r,
  output logic                          o_busy_r,
  output logic                          o_done_r
);

  localparam int AW = (N > 2) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {PEND, IDLE, INIT} state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [W-1:0]     r_fill;
  logic [BANKS-1:0] r_mask;
  logic [AW-1:0]    w_next_addr;

  // Address is zero-extended, or truncated to its low W bits when W < AW.
  function automatic logic [W-1:0] f_pattern(input logic [1:0]    mode,
                                             input logic [W-1:0]  fill,
                                             input logic [AW-1:0] addr);
    logic [W+AW-1:0] ext;
    logic [W-1:0]    a;
    ext = {{W{1'b0}}, addr};
    a   = ext[W-1:0];
    case (mode)
      2'd0:    return '0;
      2'd1:    return fill;
      2'd2:    return a;
      default: return a ^ fill;
    endcase
  endfunction

  always_comb begin
    w_next_addr = o_waddr_r + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PEND;
      r_mode    <= '0;
      r_fill    <= '0;
      r_mask    <= '0;
      o_wen_r   <= '0;
      o_waddr_r <= '0;
      o_wdata_r <= '0;
      o_done_r  <= 1'b0;
      o_busy_r  <= (INIT_ON_RESET != 0);
    end else begin
      case (r_state)
        PEND: begin
          o_done_r <= 1'b0;
          if (INIT_ON_RESET != 0) begin
            r_state   <= INIT;
            r_mode    <= 2'd0;
            r_mask    <= '1;
            o_wen_r   <= '1;
            o_waddr_r <= '0;
            o_wdata_r <= '0;
            o_busy_r  <= 1'b1;
          end else begin
            r_state  <= IDLE;
            o_busy_r <= 1'b0;
          end
        end
        IDLE: begin
          o_done_r <= 1'b0;
          o_wen_r  <= '0;
          if (i_start && (i_bank_mask != '0)) begin
            r_state   <= INIT;
            r_mode    <= i_mode;
            r_fill    <= i_fill;
            r_mask    <= i_bank_mask;
            o_wen_r   <= i_bank_mask;
            o_waddr_r <= '0;
            o_wdata_r <= f_pattern(i_mode, i_fill, '0);
            o_busy_r  <= 1'b1;
          end
        end
        INIT: begin
          o_done_r <= 1'b0;
          if (!i_stall) begin
            if (o_waddr_r == LAST_ADDR) begin
              r_state  <= IDLE;
              o_wen_r  <= '0;
              o_busy_r <= 1'b0;
              o_done_r <= 1'b1;
            end else begin
              o_waddr_r <= w_next_addr;
              o_wdata_r <= f_pattern(r_mode, r_fill, w_next_addr);
              o_wen_r   <= r_mask;
            end
          end
        end
        default: r_state <= PEND;
      endcase
    end
  end

endmodule

// File: tb/tb_v_meminit.sv
// Directed bench for v_meminit: a small 5-word dual-bank instance driven from
// a vector table, and a 256-word 4-bit instance for back-to-back passes.
module tb_v_meminit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=5, W=8, BANKS=2, auto-init
  logic       rst_a, start_a, stall_a;
  logic [1:0] mode_a, mask_a, wen_a;
  logic [7:0] fill_a, wdata_a;
  logic [2:0] waddr_a;
  logic       busy_a, done_a;

  v_meminit #(.N(5), .W(8), .BANKS(2), .INIT_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst_a), .i_start(start_a), .i_mode(mode_a), .i_fill(fill_a),
    .i_bank_mask(mask_a), .i_stall(stall_a), .o_wen_r(wen_a), .o_waddr_r(waddr_a),
    .o_wdata_r(wdata_a), .o_busy_r(busy_a), .o_done_r(done_a)
  );

  // Instance B: N=256, W=4, BANKS=1, idle after reset
  logic       rst_b, start_b, stall_b, mask_b, wen_b;
  logic [1:0] mode_b;
  logic [3:0] fill_b, wdata_b;
  logic [7:0] waddr_b;
  logic       busy_b, done_b;

  v_meminit #(.N(256), .W(4), .BANKS(1), .INIT_ON_RESET(0)) u_b (
    .clk(clk), .rst(rst_b), .i_start(start_b), .i_mode(mode_b), .i_fill(fill_b),
    .i_bank_mask(mask_b), .i_stall(stall_b), .o_wen_r(wen_b), .o_waddr_r(waddr_b),
    .o_wdata_r(wdata_b), .o_busy_r(busy_b), .o_done_r(done_b)
  );

  typedef struct {
    logic       rst, start;
    logic [1:0] mode;
    logic [7:0] fill;
    logic [1:0] mask;
    logic       stall;
    logic [1:0] e_wen;
    logic [2:0] e_addr;
    logic [7:0] e_data;
    logic       e_busy, e_done;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic rst, input logic start, input logic [1:0] mode,
                     input logic [7:0] fill, input logic [1:0] mask, input logic stall,
                     input logic [1:0] e_wen, input logic [2:0] e_addr,
                     input logic [7:0] e_data, input logic e_busy, input logic e_done);
    vec_t v;
    v = '{rst, start, mode, fill, mask, stall, e_wen, e_addr, e_data, e_busy, e_done};
    tv.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic e_wen, input logic [7:0] e_addr,
                       input logic [3:0] e_data, input logic e_busy, input logic e_done);
    nvec++;
    if (wen_b !== e_wen || waddr_b !== e_addr || wdata_b !== e_data ||
        busy_b !== e_busy || done_b !== e_done) begin
      nerr++;
      $display("FAIL %s: got wen=%b addr=%0d data=%h busy=%b done=%b, want wen=%b addr=%0d data=%h busy=%b done=%b",
               nm, wen_b, waddr_b, wdata_b, busy_b, done_b, e_wen, e_addr, e_data, e_busy, e_done);
    end
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] a8;

    rst_a = 1'b1; start_a = 1'b0; mode_a = '0; fill_a = '0; mask_a = '0; stall_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; mode_b = '0; fill_b = '0; mask_b = 1'b0; stall_b = 1'b0;

    //   rst start mode fill   mask  stall  wen    addr data   busy done
    // auto-init after reset: PEND then five zero writes to both banks
    add(1, 0, 0, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 1, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 2, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 3, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 4, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b00, 4, 8'h00, 0, 1);
    // idle with stall high, then start with an empty mask: both no-ops
    add(0, 0, 0, 8'h00, 2'b00, 1, 2'b00, 4, 8'h00, 0, 0);
    add(0, 1, 3, 8'hA5, 2'b00, 0, 2'b00, 4, 8'h00, 0, 0);
    // mode 3, fill A5, bank 1 only; stall 3 cycles at address 2; start mid-pass ignored
    add(0, 1, 3, 8'hA5, 2'b10, 0, 2'b10, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b10, 1, 8'hA4, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b10, 2, 8'hA7, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 1, 2'b10, 2, 8'hA7, 1, 0);
    add(0, 1, 0, 8'h00, 2'b11, 1, 2'b10, 2, 8'hA7, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 1, 2'b10, 2, 8'hA7, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b10, 3, 8'hA6, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b10, 4, 8'hA1, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b00, 4, 8'hA1, 0, 1);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b00, 4, 8'hA1, 0, 0);
    // mode 1 on bank 0, reset at address 3 aborts; fresh auto-init follows
    add(0, 1, 1, 8'h3C, 2'b01, 0, 2'b01, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b01, 1, 8'h3C, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b01, 2, 8'h3C, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b01, 3, 8'h3C, 1, 0);
    add(1, 0, 0, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 1, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 2, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 3, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b11, 4, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b00, 4, 8'h00, 0, 1);
    add(0, 0, 0, 8'h00, 2'b00, 0, 2'b00, 4, 8'h00, 0, 0);

    for (int unsigned k = 0; k < tv.size(); k++) begin
      rst_a = tv[k].rst; start_a = tv[k].start; mode_a = tv[k].mode;
      fill_a = tv[k].fill; mask_a = tv[k].mask; stall_a = tv[k].stall;
      tick();
      nvec++;
      if (wen_a !== tv[k].e_wen || waddr_a !== tv[k].e_addr || wdata_a !== tv[k].e_data ||
          busy_a !== tv[k].e_busy || done_a !== tv[k].e_done) begin
        nerr++;
        $display("FAIL vec%0d: got wen=%b addr=%0d data=%h busy=%b done=%b, want wen=%b addr=%0d data=%h busy=%b done=%b",
                 k, wen_a, waddr_a, wdata_a, busy_a, done_a, tv[k].e_wen, tv[k].e_addr,
                 tv[k].e_data, tv[k].e_busy, tv[k].e_done);
      end
    end

    // Instance B: reset idles, mode 2 pass, restart on the done cycle
    tick();
    chk_b("b_reset", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
    rst_b = 1'b0;
    tick();
    chk_b("b_idle", 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
    start_b = 1'b1; mode_b = 2'd2; mask_b = 1'b1; fill_b = 4'h9;
    tick();
    start_b = 1'b0;
    chk_b("b_p1_first", 1'b1, 8'd0, 4'h0, 1'b1, 1'b0);
    for (int i = 1; i < 256; i++) begin
      tick();
      a8 = 8'(i);
      chk_b("b_p1_addr", 1'b1, a8, a8[3:0], 1'b1, 1'b0);
    end
    tick();
    chk_b("b_p1_done", 1'b0, 8'd255, 4'hF, 1'b0, 1'b1);
    start_b = 1'b1; mode_b = 2'd2;
    tick();
    start_b = 1'b0;
    busy_cnt = busy_b ? 1 : 0;
    chk_b("b_p2_first", 1'b1, 8'd0, 4'h0, 1'b1, 1'b0);
    for (int i = 1; i < 256; i++) begin
      tick();
      if (busy_b) busy_cnt++;
      a8 = 8'(i);
      chk_b("b_p2_addr", 1'b1, a8, a8[3:0], 1'b1, 1'b0);
    end
    tick();
    if (busy_b) busy_cnt++;
    chk_b("b_p2_done", 1'b0, 8'd255, 4'hF, 1'b0, 1'b1);
    tick();
    chk_b("b_after", 1'b0, 8'd255, 4'hF, 1'b0, 1'b0);
    nvec++;
    if (busy_cnt != 256) begin
      nerr++;
      $display("FAIL b_busy_len: got %0d cycles, want 256", busy_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/v_meminit.md
V_MEMINIT -- requirements
Module: v_meminit

Interface
REQ-001 SHALL have parameter N, default 256: words per bank, N>=2, need not be a power of two.
REQ-002 SHALL have parameter W, default 32: word width in bits, W>=1.
REQ-003 SHALL have parameter BANKS, default 1: number of independent memory banks written in lockstep, BANKS>=1.
REQ-004 SHALL have parameter INIT_ON_RESET, default 1: 1 means auto-zero all banks after reset; 0 means idle after reset.
REQ-005 SHALL use localparam AW = max(1, $clog2(N)).
REQ-006 SHALL have port clk, input, 1 bit: clock, all flops on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port i_start, input, 1 bit: request a re-initialisation, sampled only in IDLE.
REQ-009 SHALL have port i_mode, input, 2 bits: data pattern, 0 = zero, 1 = i_fill, 2 = address, 3 = address XOR i_fill.
REQ-010 SHALL have port i_fill, input, W bits: fill constant.
REQ-011 SHALL have port i_bank_mask, input, BANKS bits: banks to write.
REQ-012 SHALL have port i_stall, input, 1 bit: memory port not ready; a write is not accepted while it is high.
REQ-013 SHALL have port o_wen_r, output, BANKS bits: per-bank write enable.
REQ-014 SHALL have port o_waddr_r, output, AW bits: write address, common to all banks.
REQ-015 SHALL have port o_wdata_r, output, W bits: write data, common to all banks.
REQ-016 SHALL have port o_busy_r, output, 1 bit: initialisation pending or in progress.
REQ-017 SHALL have port o_done_r, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 SHALL drive every output directly from a flop, with no combinational path from any input to any output.
REQ-019 SHALL implement a state machine with states PEND, IDLE and INIT.
REQ-020 SHALL transition PEND -> INIT when INIT_ON_RESET=1, and PEND -> IDLE when INIT_ON_RESET=0, after exactly one cycle.
REQ-021 SHALL, in IDLE with i_start=1 and i_bank_mask!=0, latch i_mode, i_fill and i_bank_mask and enter INIT on the next cycle.
REQ-022 SHALL treat i_start in IDLE with i_bank_mask==0 as a no-op: no state change, no writes, no o_done_r.
REQ-023 SHALL ignore i_start in PEND and INIT; re-initialisation requests are not queued.
REQ-024 SHALL, on the auto-init following PEND, use mode 0 with a bank mask of all ones.
REQ-025 SHALL, in INIT, drive o_wen_r = latched mask, o_busy_r = 1 and o_wdata_r = pattern(latched mode, o_waddr_r).
REQ-026 SHALL form the address pattern by zero-extending o_waddr_r to W bits, or truncating it to its low W bits when W<AW.
REQ-027 SHALL start every INIT pass with o_waddr_r = 0.
REQ-028 SHALL accept a write in any cycle where o_wen_r!=0 and i_stall=0.
REQ-029 SHALL, on an accepted write, increment the address by 1 on the next cycle.
REQ-030 SHALL, when i_stall=1, hold o_waddr_r, o_wdata_r and o_wen_r unchanged.
REQ-031 SHALL, on acceptance of the write at address N-1, make the next cycle IDLE with o_wen_r=0, o_busy_r=0 and o_done_r=1.
REQ-032 SHALL hold o_done_r high for exactly one cycle per completed pass.
REQ-033 SHALL never drive an address >= N, and SHALL never write any address twice in one pass.
REQ-034 SHALL, with no stalls, hold o_busy_r high for exactly N cycles per requested pass (N+1 cycles for the auto-init including PEND).
REQ-035 SHALL accept i_start in the same cycle that o_done_r=1, since the block is then IDLE; INIT begins on the next cycle.
REQ-036 SHALL, in IDLE, drive o_wen_r=0 and hold o_waddr_r and o_wdata_r at their last values.
REQ-037 SHALL treat an X on i_stall while o_wen_r==0 as don't-care.

Reset
REQ-038 SHALL, on rst=1, enter PEND and reset o_wen_r=0, o_waddr_r=0, o_wdata_r=0, o_done_r=0 and o_busy_r=INIT_ON_RESET.
REQ-039 SHALL, when rst is asserted during INIT, abort the pass with no o_done_r and no further writes, then restart per REQ-020.
REQ-040 SHALL apply reset values in the cycle after rst is sampled high, and SHALL produce no writes while rst=1 or in PEND.

Verification
REQ-041 SHALL be covered by: N=5, W=8, BANKS=2, INIT_ON_RESET=1, rst released, no stall -> PEND for 1 cycle, then o_wen_r=2'b11 with addresses 0..4 and data 0, then o_done_r pulse, with o_busy_r high for 6 cycles total.
REQ-042 SHALL be covered by: in IDLE, i_start with mode 3, i_fill=8'hA5, mask=2'b10 -> o_wen_r=2'b10 and data A5, A4, A7, A6, A1 at addresses 0..4.
REQ-043 SHALL be covered by: i_stall=1 for 3 cycles while address=2 -> address and data held for 3 cycles, with exactly one write at address 2 accepted.
REQ-044 SHALL be covered by: rst asserted while address=3 -> no o_done_r, and a fresh pass from address 0 after PEND.
REQ-045 SHALL be covered by: i_start during INIT, and i_start with mask=0 in IDLE -> both ignored, with no extra pass and no o_done_r.
REQ-046 SHALL be covered by: i_start coincident with o_done_r, N=256, W=4, mode 2 -> back-to-back pass starting the next cycle, with data equal to addr[3:0].
